seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter START_PC, default 64'd0, PC loaded on reset and on start.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin execution at START_PC; honoured only in IDLE.
REQ-005 SHALL have port icode  input  4  instruction code from fetch.
REQ-006 SHALL have port instr_valid  input  1  fetch decoded a legal icode/ifun.
REQ-007 SHALL have port imem_error  input  1  fetch address out of range.
REQ-008 SHALL have port cnd  input  1  condition result from execute.
REQ-009 SHALL have port valC  input  64  constant word from fetch.
REQ-010 SHALL have port valP  input  64  fall-through PC from fetch.
REQ-011 SHALL have port valM  input  64  data read by memory stage.
REQ-012 SHALL have port dmem_error  input  1  data memory address error.
REQ-013 SHALL have port PC  output  64  current instruction address driven to fetch.
REQ-014 SHALL have ports fetch_en, decode_en, execute_en, memory_en, wb_en  output  1 each  stage enables.
REQ-015 SHALL have port set_cc  output  1  condition-code register load strobe.
REQ-016 SHALL have port stat  output  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-017 SHALL have ports busy, halted  output  1 each  running / stopped flags.
REQ-018 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; one state per clock.
REQ-020 SHALL go IDLE->FETCH on start=1, loading PC=START_PC, stat=AOK, instr_count=0.
REQ-021 SHALL sequence FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD->FETCH absent errors.
REQ-022 SHALL assert exactly the one stage enable matching the current state; all enables 0 in IDLE, PCUPD, HALT.
REQ-023 SHALL latch icode into icode_q at end of FETCH; later decisions use icode_q only.
REQ-024 SHALL, at end of FETCH, check in priority order: imem_error -> stat=ADR; !instr_valid -> stat=INS; icode=0 -> stat=HLT; any hit goes to HALT, PC unchanged.
REQ-025 SHALL pulse set_cc for exactly the EXECUTE cycle when icode_q=6 (OPq); else 0.
REQ-026 SHALL latch cnd at end of EXECUTE and valM at end of MEMORY.
REQ-027 SHALL, on dmem_error at end of MEMORY, set stat=ADR and go HALT, skipping WRITEBACK and PC update.
REQ-028 SHALL in PCUPD load PC = valC if icode_q=8 or (icode_q=7 and cnd latched 1); valM if icode_q=9; else valP.
REQ-029 SHALL increment instr_count by 1 in PCUPD, wrapping 32'hFFFFFFFF->0.
REQ-030 SHALL hold HALT until reset; start ignored in every state except IDLE.
REQ-031 SHALL drive busy=1 in FETCH..PCUPD, halted=1 only in HALT.
REQ-032 SHALL count a halt instruction as not retired (instr_count unchanged).

Reset
REQ-033 SHALL on rst_n=0, immediately and regardless of state: state=IDLE, PC=START_PC, stat=AOK, instr_count=0, all enables/set_cc/busy/halted=0, icode_q=0.
REQ-034 SHALL resume only via start after rst_n deasserts; reset mid-instruction discards it.

Verification
REQ-035 SHALL test: start, icode=1 (nop), valP=2 -> enables one-hot over 5 cycles, PC=2 after PCUPD, instr_count=1.
REQ-036 SHALL test: icode=7, cnd=1, valC=0x40, valP=9 -> PC=0x40; repeat with cnd=0 -> PC=9.
REQ-037 SHALL test: icode=9, valM=0x100 -> PC=0x100; icode=6 -> set_cc high exactly one cycle in EXECUTE.
REQ-038 SHALL test: icode=0 -> stat=2, halted=1, PC unchanged; start pulse -> no change.
REQ-039 SHALL test: imem_error=1 with instr_valid=0 -> stat=3 (not 4); dmem_error in MEMORY -> stat=3, wb_en never asserted.
REQ-040 SHALL test: rst_n low during EXECUTE -> all outputs at reset values same cycle, PC=START_PC.

Source files
------------

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for a Y86-64 style core: walks one instruction through
// fetch..PC update, raises per-stage enables and tracks status/retire count.
module seq_ctrl #(
   parameter logic [63:0] START_PC = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        cnd,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   input  logic        dmem_error,
   output logic [63:0] PC,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        execute_en,
   output logic        memory_en,
   output logic        wb_en,
   output logic        set_cc,
   output logic [2:0]  stat,
   output logic        busy,
   output logic        halted,
   output logic [31:0] instr_count
);

   localparam int unsigned XW = 64;
   localparam int unsigned CW = 32;
   localparam int unsigned SW = 3;
   localparam int unsigned IW = 4;

   localparam logic [SW-1:0] STAT_AOK = SW'(1);
   localparam logic [SW-1:0] STAT_HLT = SW'(2);
   localparam logic [SW-1:0] STAT_ADR = SW'(3);
   localparam logic [SW-1:0] STAT_INS = SW'(4);

   localparam logic [IW-1:0] IC_HALT = IW'(0);
   localparam logic [IW-1:0] IC_OPQ  = IW'(6);
   localparam logic [IW-1:0] IC_JXX  = IW'(7);
   localparam logic [IW-1:0] IC_CALL = IW'(8);
   localparam logic [IW-1:0] IC_RET  = IW'(9);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
   } state_t;

   state_t        state, state_nxt;
   logic [XW-1:0] pc_nxt;
   logic [SW-1:0] stat_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [IW-1:0] icode_q, icode_q_nxt;
   logic          cnd_q, cnd_q_nxt;
   logic [XW-1:0] valm_q, valm_q_nxt;
   logic          fetch_en_nxt, decode_en_nxt, execute_en_nxt, memory_en_nxt, wb_en_nxt;
   logic          set_cc_nxt, busy_nxt, halted_nxt;

   // Next-state, datapath updates and registered-output decode of the next state
   always_comb begin
      state_nxt   = state;
      pc_nxt      = PC;
      stat_nxt    = stat;
      cnt_nxt     = instr_count;
      icode_q_nxt = icode_q;
      cnd_q_nxt   = cnd_q;
      valm_q_nxt  = valm_q;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = START_PC;
               stat_nxt  = STAT_AOK;
               cnt_nxt   = '0;
            end
         end
         S_FETCH: begin
            icode_q_nxt = icode;
            // Address fault outranks illegal-instruction, which outranks halt
            if (imem_error) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_HALT;
            end else if (!instr_valid) begin
               stat_nxt  = STAT_INS;
               state_nxt = S_HALT;
            end else if (icode == IC_HALT) begin
               stat_nxt  = STAT_HLT;
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: state_nxt = S_EXECUTE;
         S_EXECUTE: begin
            cnd_q_nxt = cnd;
            state_nxt = S_MEMORY;
         end
         S_MEMORY: begin
            valm_q_nxt = valM;
            if (dmem_error) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_WRITEBACK: state_nxt = S_PCUPD;
         S_PCUPD: begin
            if (icode_q == IC_CALL || (icode_q == IC_JXX && cnd_q))
               pc_nxt = valC;
            else if (icode_q == IC_RET)
               pc_nxt = valm_q;
            else
               pc_nxt = valP;
            cnt_nxt   = instr_count + CW'(1);
            state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase

      fetch_en_nxt   = (state_nxt == S_FETCH);
      decode_en_nxt  = (state_nxt == S_DECODE);
      execute_en_nxt = (state_nxt == S_EXECUTE);
      memory_en_nxt  = (state_nxt == S_MEMORY);
      wb_en_nxt      = (state_nxt == S_WRITEBACK);
      set_cc_nxt     = (state_nxt == S_EXECUTE) && (icode_q_nxt == IC_OPQ);
      busy_nxt       = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halted_nxt     = (state_nxt == S_HALT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         PC          <= START_PC;
         stat        <= STAT_AOK;
         instr_count <= '0;
         icode_q     <= '0;
         cnd_q       <= 1'b0;
         valm_q      <= '0;
         fetch_en    <= 1'b0;
         decode_en   <= 1'b0;
         execute_en  <= 1'b0;
         memory_en   <= 1'b0;
         wb_en       <= 1'b0;
         set_cc      <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nxt;
         PC          <= pc_nxt;
         stat        <= stat_nxt;
         instr_count <= cnt_nxt;
         icode_q     <= icode_q_nxt;
         cnd_q       <= cnd_q_nxt;
         valm_q      <= valm_q_nxt;
         fetch_en    <= fetch_en_nxt;
         decode_en   <= decode_en_nxt;
         execute_en  <= execute_en_nxt;
         memory_en   <= memory_en_nxt;
         wb_en       <= wb_en_nxt;
         set_cc      <= set_cc_nxt;
         busy        <= busy_nxt;
         halted      <= halted_nxt;
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl: instruction flows, PC selection,
// halt/fault status, and asynchronous reset mid-instruction.
module tb_seq_ctrl;

   localparam logic [63:0] SPC = 64'h1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_error;
   logic        cnd;
   logic [63:0] valC, valP, valM;
   logic        dmem_error;
   logic [63:0] PC;
   logic        fetch_en, decode_en, execute_en, memory_en, wb_en;
   logic        set_cc;
   logic [2:0]  stat;
   logic        busy, halted;
   logic [31:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_cnt;

   seq_ctrl #(.START_PC(SPC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
      .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
      .valC(valC), .valP(valP), .valM(valM), .dmem_error(dmem_error),
      .PC(PC), .fetch_en(fetch_en), .decode_en(decode_en),
      .execute_en(execute_en), .memory_en(memory_en), .wb_en(wb_en),
      .set_cc(set_cc), .stat(stat), .busy(busy), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [4:0] ens();
      return {fetch_en, decode_en, execute_en, memory_en, wb_en};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_pc"},   PC, SPC);
      check_val({tag, "_stat"}, 64'(stat), 64'd1);
      check_val({tag, "_cnt"},  64'(instr_count), 64'd0);
      check_val({tag, "_en"},   64'(ens()), 64'd0);
      check_val({tag, "_cc"},   64'(set_cc), 64'd0);
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_halt"}, 64'(halted), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_valid = 1'b1;
      imem_error = 1'b0; cnd = 1'b0; valC = '0; valP = '0; valM = '0;
      dmem_error = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one instruction from FETCH; inputs are only valid in the stage that consumes them
   task automatic run_instr(input string tag, input logic [3:0] ic, input logic c,
                            input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                            input logic dm_err, input logic [63:0] exp_pc);
      logic exp_cc;
      exp_cc = (ic == 4'd6);
      icode = ic; instr_valid = 1'b1; imem_error = 1'b0; valC = vc; valP = vp;
      cnd = ~c; valM = ~vm; dmem_error = 1'b0;
      check_val({tag, "_f_en"}, 64'(ens()), 64'b10000);
      check_val({tag, "_f_busy"}, 64'(busy), 64'd1);
      check_val({tag, "_f_cc"}, 64'(set_cc), 64'd0);
      tick();
      icode = 4'h0;
      check_val({tag, "_d_en"}, 64'(ens()), 64'b01000);
      check_val({tag, "_d_cc"}, 64'(set_cc), 64'd0);
      tick();
      cnd = c;
      check_val({tag, "_e_en"}, 64'(ens()), 64'b00100);
      check_val({tag, "_e_cc"}, 64'(set_cc), 64'(exp_cc));
      tick();
      cnd = ~c; valM = vm; dmem_error = dm_err;
      check_val({tag, "_m_en"}, 64'(ens()), 64'b00010);
      check_val({tag, "_m_cc"}, 64'(set_cc), 64'd0);
      tick();
      valM = ~vm; dmem_error = 1'b0;
      if (dm_err) begin
         check_val({tag, "_dm_stat"}, 64'(stat), 64'd3);
         check_val({tag, "_dm_halt"}, 64'(halted), 64'd1);
         check_val({tag, "_dm_en"}, 64'(ens()), 64'd0);
         check_val({tag, "_dm_cnt"}, 64'(instr_count), 64'(exp_cnt));
         return;
      end
      check_val({tag, "_w_en"}, 64'(ens()), 64'b00001);
      tick();
      check_val({tag, "_p_en"}, 64'(ens()), 64'd0);
      check_val({tag, "_p_busy"}, 64'(busy), 64'd1);
      tick();
      exp_cnt = exp_cnt + 32'd1;
      check_val({tag, "_pc"}, PC, exp_pc);
      check_val({tag, "_cnt"}, 64'(instr_count), 64'(exp_cnt));
      check_val({tag, "_stat"}, 64'(stat), 64'd1);
   endtask

   initial begin
      do_reset();
      check_reset_outs("reset");
      tick();
      check_val("idle_busy", 64'(busy), 64'd0);

      do_start();
      check_val("start_pc", PC, SPC);
      run_instr("nop",    4'd1, 1'b0, 64'h0,    64'h2,    64'h0,   1'b0, 64'h2);
      run_instr("jxx_t",  4'd7, 1'b1, 64'h40,   64'h9,    64'h0,   1'b0, 64'h40);
      run_instr("jxx_nt", 4'd7, 1'b0, 64'h40,   64'h9,    64'h0,   1'b0, 64'h9);
      run_instr("ret",    4'd9, 1'b0, 64'h55,   64'h77,   64'h100, 1'b0, 64'h100);
      run_instr("call",   4'd8, 1'b0, 64'h2000, 64'h10,   64'h0,   1'b0, 64'h2000);
      run_instr("opq",    4'd6, 1'b1, 64'h33,   64'h2010, 64'h0,   1'b0, 64'h2010);

      // Halt instruction: stop with PC and count untouched, then start is ignored
      icode = 4'd0; instr_valid = 1'b1;
      tick();
      icode = 4'd1;
      check_val("hlt_stat", 64'(stat), 64'd2);
      check_val("hlt_halted", 64'(halted), 64'd1);
      check_val("hlt_busy", 64'(busy), 64'd0);
      check_val("hlt_en", 64'(ens()), 64'd0);
      check_val("hlt_pc", PC, 64'h2010);
      check_val("hlt_cnt", 64'(instr_count), 64'd6);
      start = 1'b1;
      tick(); tick();
      start = 1'b0;
      tick();
      check_val("hlt_start_stat", 64'(stat), 64'd2);
      check_val("hlt_start_halted", 64'(halted), 64'd1);
      check_val("hlt_start_pc", PC, 64'h2010);
      check_val("hlt_start_en", 64'(ens()), 64'd0);

      // imem_error outranks an illegal instruction
      do_reset();
      do_start();
      imem_error = 1'b1; instr_valid = 1'b0; icode = 4'd1;
      tick();
      imem_error = 1'b0; instr_valid = 1'b1;
      check_val("imem_stat", 64'(stat), 64'd3);
      check_val("imem_halted", 64'(halted), 64'd1);
      check_val("imem_pc", PC, SPC);

      // Illegal instruction alone
      do_reset();
      do_start();
      instr_valid = 1'b0;
      tick();
      instr_valid = 1'b1;
      check_val("ins_stat", 64'(stat), 64'd4);
      check_val("ins_halted", 64'(halted), 64'd1);

      // Data memory fault skips writeback and PC update
      do_reset();
      do_start();
      run_instr("dmem", 4'd5, 1'b0, 64'h0, 64'h4, 64'h0, 1'b1, SPC);
      check_val("dmem_pc", PC, SPC);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("dmem_wb", 64'(wb_en), 64'd0);
      end

      // Asynchronous reset in the middle of an OPq execute
      do_reset();
      do_start();
      run_instr("pre_rst", 4'd1, 1'b0, 64'h0, 64'h2, 64'h0, 1'b0, 64'h2);
      icode = 4'd6;
      tick();
      tick();
      check_val("pre_rst_cc", 64'(set_cc), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outs("async_rst");
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check_val("post_rst_busy", 64'(busy), 64'd0);
      check_val("post_rst_pc", PC, SPC);
      exp_cnt = '0;
      do_start();
      run_instr("resume", 4'd1, 1'b0, 64'h0, 64'h18, 64'h0, 1'b0, 64'h18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
